// File: rtl/digit_bus_arbiter.sv
// digit_bus_arbiter: round-robin arbiter sharing the seven-segment display
// register block between N_REQ requesters. It serialises single-beat writes
// and reads, and supports a timed-out lock for read-modify-write sequences.
//
// state  | meaning
// S_IDLE | arbitrate, capture the winner's command
// S_WR   | drive the display write for one cycle
// S_RA   | present the read address for one cycle
// S_RD   | return the read data to the owner for one cycle
module digit_bus_arbiter #(
  parameter int N_REQ        = 2,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0]      req_we,
  input  logic [N_REQ-1:0]      req_lock,
  input  logic [8*N_REQ-1:0]    req_addr,
  input  logic [4*N_REQ-1:0]    req_be,
  input  logic [32*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  lock_err,
  output logic [7:0]            dig_addr,
  output logic [3:0]            dig_be,
  output logic [31:0]           dig_wdata,
  output logic [7:0]            dig_raddr,
  input  logic [31:0]           dig_rdata
);

  localparam int PW = (N_REQ > 2) ? 2 : 1;
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RA, S_RD} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic              lock_q, lock_d;
  logic              cap_lock_q, cap_lock_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        dig_addr_q, dig_addr_d;
  logic [3:0]        dig_be_q, dig_be_d;
  logic [31:0]       dig_wdata_q, dig_wdata_d;
  logic [7:0]        dig_raddr_q, dig_raddr_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic              lock_err_q, lock_err_d;

  logic              grant_any;
  logic              grant;
  logic [PW-1:0]     win_idx;

  // Pick the winner: the lock owner only, otherwise first valid at/after the pointer.
  always_comb begin
    grant_any = 1'b0;
    win_idx   = '0;
    if (lock_q) begin
      grant_any = req_valid[owner_q];
      win_idx   = owner_q;
    end else begin
      // Descending scan so the lowest rotating offset is the last one written.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (req_valid[(int'(ptr_q) + k) % N_REQ]) begin
          grant_any = 1'b1;
          win_idx   = PW'((int'(ptr_q) + k) % N_REQ);
        end
      end
    end
  end

  assign grant = grant_any && (state_q == S_IDLE);

  // One-hot ready to the winner, suppressed while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (grant && !rst) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Next-state, capture, lock and timeout logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    lock_d      = lock_q;
    cap_lock_d  = cap_lock_q;
    cnt_d       = cnt_q;
    dig_addr_d  = dig_addr_q;
    dig_be_d    = '0;
    dig_wdata_d = dig_wdata_q;
    dig_raddr_d = dig_raddr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = '0;
    lock_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          owner_d    = win_idx;
          ptr_d      = PW'((int'(win_idx) + 1) % N_REQ);
          cap_lock_d = req_lock[win_idx];
          // Lock takes effect at grant; a lock=0 command releases it on completion.
          lock_d     = lock_q | req_lock[win_idx];
          cnt_d      = '0;
          if (req_we[win_idx]) begin
            state_d     = S_WR;
            dig_addr_d  = req_addr[int'(win_idx)*8 +: 8];
            dig_be_d    = req_be[int'(win_idx)*4 +: 4];
            dig_wdata_d = req_data[int'(win_idx)*32 +: 32];
          end else begin
            state_d     = S_RA;
            dig_raddr_d = req_addr[int'(win_idx)*8 +: 8];
          end
        end else if (lock_q && !req_valid[owner_q]) begin
          if (cnt_q == CNT_LAST) begin
            lock_d     = 1'b0;
            cnt_d      = '0;
            lock_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_WR: begin
        state_d = S_IDLE;
        lock_d  = cap_lock_q;
      end
      S_RA: begin
        state_d              = S_RD;
        rsp_data_d           = dig_rdata;
        rsp_valid_d[owner_q] = 1'b1;
      end
      S_RD: begin
        state_d = S_IDLE;
        lock_d  = cap_lock_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      lock_q      <= 1'b0;
      cap_lock_q  <= 1'b0;
      cnt_q       <= '0;
      dig_addr_q  <= '0;
      dig_be_q    <= '0;
      dig_wdata_q <= '0;
      dig_raddr_q <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      lock_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      lock_q      <= lock_d;
      cap_lock_q  <= cap_lock_d;
      cnt_q       <= cnt_d;
      dig_addr_q  <= dig_addr_d;
      dig_be_q    <= dig_be_d;
      dig_wdata_q <= dig_wdata_d;
      dig_raddr_q <= dig_raddr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      lock_err_q  <= lock_err_d;
    end
  end

  assign dig_addr  = dig_addr_q;
  assign dig_be    = dig_be_q;
  assign dig_wdata = dig_wdata_q;
  assign dig_raddr = dig_raddr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign lock_err  = lock_err_q;

endmodule

// File: tb/tb_digit_bus_arbiter.sv
// Bench for digit_bus_arbiter (two requesters, lock timeout of 8 cycles).
module tb_digit_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we, req_lock;
  logic [15:0] req_addr;
  logic [7:0]  req_be;
  logic [63:0] req_data;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic        lock_err;
  logic [7:0]  dig_addr;
  logic [3:0]  dig_be;
  logic [31:0] dig_wdata;
  logic [7:0]  dig_raddr;
  logic [31:0] dig_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_bus_arbiter #(.N_REQ(2), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_be(req_be), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .lock_err(lock_err),
    .dig_addr(dig_addr), .dig_be(dig_be), .dig_wdata(dig_wdata),
    .dig_raddr(dig_raddr), .dig_rdata(dig_rdata)
  );

  typedef struct {
    logic [1:0]  v, we, lk;
    logic [15:0] addr;
    logic [7:0]  be;
    logic [63:0] wd;
    logic [31:0] rd;
    logic [1:0]  e_rdy, e_rsv;
    logic [3:0]  e_be;
    logic [7:0]  e_addr;
    logic [31:0] e_wd;
    logic [7:0]  e_raddr;
    logic [31:0] e_rsp;
    logic        e_lerr;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [15:0] addr, input logic [7:0] be,
                       input logic [63:0] wd, input logic [31:0] rd);
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    req_addr  = addr;
    req_be    = be;
    req_data  = wd;
    dig_rdata = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " ready"},   64'(req_ready), 64'h0);
    chk({tag, " rsp_v"},   64'(rsp_valid), 64'h0);
    chk({tag, " rsp_d"},   64'(rsp_data),  64'h0);
    chk({tag, " lerr"},    64'(lock_err),  64'h0);
    chk({tag, " d_addr"},  64'(dig_addr),  64'h0);
    chk({tag, " d_be"},    64'(dig_be),    64'h0);
    chk({tag, " d_wd"},    64'(dig_wdata), 64'h0);
    chk({tag, " d_raddr"}, 64'(dig_raddr), 64'h0);
  endtask

  // Reset with requests pending; ready must stay low while rst is high.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive(2'b11, 2'b11, 2'b00, 16'h1234, 8'hFF, 64'h1, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero(tag);
    drive(2'b00, 2'b00, 2'b00, 16'h0, 8'h0, 64'h0, 32'h0);
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{2'b01, 2'b01, 2'b00, 16'h0001, 8'h01, 64'h0000_0000_0000_000F, 32'h0,
                 2'b01, 2'b00, 4'h0, 8'h00, 32'h0, 8'h00, 32'h0, 1'b0};
    vecs[1]  = '{2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 64'h0, 32'h0,
                 2'b00, 2'b00, 4'h1, 8'h01, 32'h0000_000F, 8'h00, 32'h0, 1'b0};
    vecs[2]  = '{2'b10, 2'b00, 2'b00, 16'h0001, 8'h00, 64'h0, 32'h0021_2223,
                 2'b10, 2'b00, 4'h0, 8'h01, 32'h0000_000F, 8'h00, 32'h0, 1'b0};
    vecs[3]  = '{2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 64'h0, 32'h0021_2223,
                 2'b00, 2'b00, 4'h0, 8'h01, 32'h0000_000F, 8'h00, 32'h0, 1'b0};
    vecs[4]  = '{2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 64'h0, 32'h0,
                 2'b00, 2'b10, 4'h0, 8'h01, 32'h0000_000F, 8'h00, 32'h0021_2223, 1'b0};
    vecs[5]  = '{2'b11, 2'b11, 2'b00, 16'h2010, 8'hC3, 64'hBBBB_0002_AAAA_0001, 32'h0,
                 2'b01, 2'b00, 4'h0, 8'h01, 32'h0000_000F, 8'h00, 32'h0021_2223, 1'b0};
    vecs[6]  = '{2'b10, 2'b11, 2'b00, 16'h2010, 8'hC3, 64'hBBBB_0002_AAAA_0001, 32'h0,
                 2'b00, 2'b00, 4'h3, 8'h10, 32'hAAAA_0001, 8'h00, 32'h0021_2223, 1'b0};
    vecs[7]  = '{2'b10, 2'b11, 2'b00, 16'h2010, 8'hC3, 64'hBBBB_0002_AAAA_0001, 32'h0,
                 2'b10, 2'b00, 4'h0, 8'h10, 32'hAAAA_0001, 8'h00, 32'h0021_2223, 1'b0};
    vecs[8]  = '{2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 64'h0, 32'h0,
                 2'b00, 2'b00, 4'hC, 8'h20, 32'hBBBB_0002, 8'h00, 32'h0021_2223, 1'b0};
    vecs[9]  = '{2'b01, 2'b01, 2'b00, 16'h0033, 8'h00, 64'h0000_0000_1234_5678, 32'h0,
                 2'b01, 2'b00, 4'h0, 8'h20, 32'hBBBB_0002, 8'h00, 32'h0021_2223, 1'b0};
    vecs[10] = '{2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 64'h0, 32'h0,
                 2'b00, 2'b00, 4'h0, 8'h33, 32'h1234_5678, 8'h00, 32'h0021_2223, 1'b0};
    vecs[11] = '{2'b11, 2'b00, 2'b00, 16'h4455, 8'h00, 64'h0, 32'hCAFE_F00D,
                 2'b10, 2'b00, 4'h0, 8'h33, 32'h1234_5678, 8'h00, 32'h0021_2223, 1'b0};
    vecs[12] = '{2'b01, 2'b00, 2'b00, 16'h4455, 8'h00, 64'h0, 32'hCAFE_F00D,
                 2'b00, 2'b00, 4'h0, 8'h33, 32'h1234_5678, 8'h44, 32'h0021_2223, 1'b0};
    vecs[13] = '{2'b01, 2'b00, 2'b00, 16'h4455, 8'h00, 64'h0, 32'hDEAD_BEEF,
                 2'b00, 2'b10, 4'h0, 8'h33, 32'h1234_5678, 8'h44, 32'hCAFE_F00D, 1'b0};
    vecs[14] = '{2'b01, 2'b00, 2'b00, 16'h4455, 8'h00, 64'h0, 32'hDEAD_BEEF,
                 2'b01, 2'b00, 4'h0, 8'h33, 32'h1234_5678, 8'h44, 32'hCAFE_F00D, 1'b0};
    vecs[15] = '{2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 64'h0, 32'hDEAD_BEEF,
                 2'b00, 2'b00, 4'h0, 8'h33, 32'h1234_5678, 8'h55, 32'hCAFE_F00D, 1'b0};
    vecs[16] = '{2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 64'h0, 32'h0,
                 2'b00, 2'b01, 4'h0, 8'h33, 32'h1234_5678, 8'h55, 32'hDEAD_BEEF, 1'b0};
    vecs[17] = '{2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 64'h0, 32'h0,
                 2'b00, 2'b00, 4'h0, 8'h33, 32'h1234_5678, 8'h55, 32'hDEAD_BEEF, 1'b0};

    // Table: single write, read from req1, rotation, be=0 write, back-to-back reads.
    do_reset("rst0");
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v, vecs[i].we, vecs[i].lk, vecs[i].addr, vecs[i].be, vecs[i].wd, vecs[i].rd);
      @(negedge clk);
      chk($sformatf("row%0d ready", i),   64'(req_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("row%0d rsp_v", i),   64'(rsp_valid), 64'(vecs[i].e_rsv));
      chk($sformatf("row%0d d_be", i),    64'(dig_be),    64'(vecs[i].e_be));
      chk($sformatf("row%0d d_addr", i),  64'(dig_addr),  64'(vecs[i].e_addr));
      chk($sformatf("row%0d d_wd", i),    64'(dig_wdata), 64'(vecs[i].e_wd));
      chk($sformatf("row%0d d_raddr", i), 64'(dig_raddr), 64'(vecs[i].e_raddr));
      chk($sformatf("row%0d rsp_d", i),   64'(rsp_data),  64'(vecs[i].e_rsp));
      chk($sformatf("row%0d lerr", i),    64'(lock_err),  64'(vecs[i].e_lerr));
      next_cycle();
    end

    // Both requesters hold writes: grants alternate 0,1,0,1 two cycles apart.
    do_reset("rst1");
    drive(2'b11, 2'b11, 2'b00, 16'h0201, 8'hFF, 64'h2222_2222_1111_1111, 32'h0);
    for (int c = 0; c < 8; c++) begin
      logic [1:0] exp_rdy;
      exp_rdy = 2'b00;
      if (c % 2 == 0) exp_rdy = ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      chk($sformatf("alt c%0d ready", c), 64'(req_ready), 64'(exp_rdy));
      next_cycle();
    end

    // Locked read-modify-write by req0 while req1 waits.
    do_reset("rst2");
    for (int c = 0; c < 9; c++) begin
      logic [1:0] exp_rdy;
      logic [1:0] v;
      logic [1:0] we;
      logic [1:0] lk;
      v  = 2'b10;
      we = 2'b10;
      lk = 2'b00;
      if (c == 0) begin v = 2'b11; lk = 2'b01; end
      if (c == 5) begin v = 2'b11; we = 2'b11; end
      drive(v, we, lk, 16'h0203, 8'hFF, 64'h5555_5555_6666_6666, 32'h0000_0042);
      exp_rdy = (c == 0 || c == 5) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
      @(negedge clk);
      chk($sformatf("lock c%0d ready", c), 64'(req_ready), 64'(exp_rdy));
      if (c == 2) chk("lock rsp_v", 64'(rsp_valid), 64'h1);
      if (c == 2) chk("lock rsp_d", 64'(rsp_data), 64'h42);
      next_cycle();
    end

    // Lock timeout: req0 locks with a write and goes quiet; release after 8 idle cycles.
    do_reset("rst3");
    for (int c = 0; c < 12; c++) begin
      logic [1:0] exp_rdy;
      drive((c == 0) ? 2'b11 : 2'b10, 2'b11, 2'b01, 16'h0405, 8'hFF, 64'h0, 32'h0);
      exp_rdy = (c == 0) ? 2'b01 : (c == 10) ? 2'b10 : 2'b00;
      @(negedge clk);
      chk($sformatf("tmo c%0d ready", c), 64'(req_ready), 64'(exp_rdy));
      chk($sformatf("tmo c%0d lerr", c),  64'(lock_err),  64'((c == 10) ? 1 : 0));
      next_cycle();
    end

    // Reset during the read-address cycle aborts the read.
    do_reset("rst4");
    drive(2'b10, 2'b00, 2'b00, 16'h7700, 8'h00, 64'h0, 32'h1111_2222);
    @(negedge clk);
    chk("abort grant", 64'(req_ready), 64'h2);
    next_cycle();
    @(negedge clk);
    chk("abort raddr", 64'(dig_raddr), 64'h77);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 16'h0, 8'h0, 64'h0, 32'h1111_2222);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort c%0d rsp_v", c), 64'(rsp_valid), 64'h0);
      chk($sformatf("abort c%0d rsp_d", c), 64'(rsp_data),  64'h0);
      next_cycle();
    end
    drive(2'b01, 2'b01, 2'b00, 16'h0009, 8'h0F, 64'h0000_0000_0000_00AA, 32'h0);
    @(negedge clk);
    chk("abort idle grant", 64'(req_ready), 64'h1);
    next_cycle();
    @(negedge clk);
    chk("abort then write be", 64'(dig_be), 64'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
